// File: rtl/shift_frame_engine.sv
// Full-duplex WIDTH-bit frame shifter: LANES bits out and in per step, one step every DIV cycles.
// Optional feature macro SHIFT_FRAME_ENGINE_B2B_EN: accept the next load during the DONE cycle.
module shift_frame_engine #(
    parameter int WIDTH = 8,
    parameter int LANES = 1,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             sclr,
    input  logic             dir,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic [LANES-1:0] sin,
    output logic [LANES-1:0] sout,
    output logic             shift_tick,
    output logic             busy,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data
);

    localparam int N     = WIDTH / LANES;
    localparam int CNT_W = $clog2(N + 1);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] STEPS      = CNT_W'(N);

`ifdef SHIFT_FRAME_ENGINE_B2B_EN
    localparam bit B2B_EN = 1'b1;
`else
    localparam bit B2B_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic             r_dir;
    logic [CNT_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic             r_s_ready;
    logic             r_busy;
    logic             r_m_valid;

    logic [WIDTH-1:0] w_q_right;
    logic [WIDTH-1:0] w_q_left;
    logic [WIDTH-1:0] w_q_next;
    logic             w_tick;
    logic             w_load;

    // A single-step frame replaces the whole register with the incoming lanes.
    generate
        if (WIDTH == LANES) begin : g_one_step
            assign w_q_right = sin;
            assign w_q_left  = sin;
        end else begin : g_multi_step
            assign w_q_right = {sin, r_q[WIDTH-1:LANES]};
            assign w_q_left  = {r_q[WIDTH-LANES-1:0], sin};
        end
    endgenerate

    assign w_q_next = r_dir ? w_q_left : w_q_right;
    assign w_tick   = (r_state == SHIFT) && (r_div == '0);
    assign w_load   = s_valid && r_s_ready;

    always_ff @(posedge clk or negedge clrn) begin
        // NOTE: all state is updated with non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!clrn) begin
            r_state   <= IDLE;
            r_q       <= '0;
            r_dir     <= 1'b0;
            r_cnt     <= '0;
            r_div     <= '0;
            r_s_ready <= 1'b1;
            r_busy    <= 1'b0;
            r_m_valid <= 1'b0;
        end else if (!sclr) begin
            r_state   <= IDLE;
            r_q       <= '0;
            r_dir     <= 1'b0;
            r_cnt     <= '0;
            r_div     <= '0;
            r_s_ready <= 1'b1;
            r_busy    <= 1'b0;
            r_m_valid <= 1'b0;
        end else if (w_load) begin
            // Only reachable from IDLE, or from DONE when back-to-back loads are enabled.
            r_state   <= SHIFT;
            r_q       <= s_data;
            r_dir     <= dir;
            r_cnt     <= STEPS;
            r_div     <= DIV_RELOAD;
            r_s_ready <= 1'b0;
            r_busy    <= 1'b1;
            r_m_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_s_ready <= 1'b1;
                end
                SHIFT: begin
                    if (w_tick) begin
                        r_q   <= w_q_next;
                        r_div <= DIV_RELOAD;
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state   <= DONE;
                            r_busy    <= 1'b0;
                            r_m_valid <= 1'b1;
                            r_s_ready <= B2B_EN;
                        end
                    end else begin
                        r_div <= r_div - DIV_W'(1);
                    end
                end
                DONE: begin
                    r_state   <= IDLE;
                    r_m_valid <= 1'b0;
                    r_s_ready <= 1'b1;
                end
                default: begin
                    r_state   <= IDLE;
                    r_s_ready <= 1'b1;
                    r_busy    <= 1'b0;
                    r_m_valid <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready    = r_s_ready;
    assign busy       = r_busy;
    assign m_valid    = r_m_valid;
    assign m_data     = r_q;
    assign shift_tick = w_tick;
    assign sout       = r_dir ? r_q[WIDTH-1 -: LANES] : r_q[LANES-1:0];

endmodule

// File: tb/tb_shift_frame_engine.sv
// Directed bench for shift_frame_engine: serial instance (8,1,1) driven from a vector table,
// plus a two-lane divided instance (8,2,3) and hand-written abort/back-to-back sequences.
module tb_shift_frame_engine;

`ifdef SHIFT_FRAME_ENGINE_B2B_EN
    localparam int PERIOD = 9;
`else
    localparam int PERIOD = 10;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clrn;
    logic       sclr;
    logic       dir;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic [0:0] sin;
    logic [0:0] sout;
    logic       shift_tick;
    logic       busy;
    logic       m_valid;
    logic [7:0] m_data;

    logic       b_s_valid;
    logic       b_s_ready;
    logic [7:0] b_s_data;
    logic [1:0] b_sin;
    logic [1:0] b_sout;
    logic       b_shift_tick;
    logic       b_busy;
    logic       b_m_valid;
    logic [7:0] b_m_data;

    shift_frame_engine #(.WIDTH(8), .LANES(1), .DIV(1)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .sclr       (sclr),
        .dir        (dir),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .sin        (sin),
        .sout       (sout),
        .shift_tick (shift_tick),
        .busy       (busy),
        .m_valid    (m_valid),
        .m_data     (m_data)
    );

    shift_frame_engine #(.WIDTH(8), .LANES(2), .DIV(3)) dut_b (
        .clk        (clk),
        .clrn       (clrn),
        .sclr       (1'b1),
        .dir        (1'b0),
        .s_valid    (b_s_valid),
        .s_ready    (b_s_ready),
        .s_data     (b_s_data),
        .sin        (b_sin),
        .sout       (b_sout),
        .shift_tick (b_shift_tick),
        .busy       (b_busy),
        .m_valid    (b_m_valid),
        .m_data     (b_m_data)
    );

    // sin_seq[k] is driven for shift k+1; sout_seq[k] is expected before shift k+1.
    typedef struct {
        logic [7:0] data;
        logic       dir;
        logic [7:0] sin_seq;
        logic [7:0] sout_seq;
        logic [7:0] exp_m;
    } vec_t;

    vec_t vecs [4];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full frame on the serial instance; inject >= 0 pulses a rival load at that step.
    task automatic run_frame(input vec_t v, input int inject);
        check("ready_before_load", s_ready, 1'b1);
        s_data  = v.data;
        dir     = v.dir;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        check("ready_after_load", s_ready, 1'b0);
        for (int k = 0; k < 8; k++) begin
            check("sout", sout, v.sout_seq[k]);
            check("shift_tick", shift_tick, 1'b1);
            check("busy", busy, 1'b1);
            check("m_valid_early", m_valid, 1'b0);
            sin = v.sin_seq[k];
            if (k == inject) begin
                check("ready_mid_frame", s_ready, 1'b0);
                s_valid = 1'b1;
                s_data  = ~v.data;
                dir     = ~v.dir;
            end
            step();
            s_valid = 1'b0;
        end
        check("m_valid_done", m_valid, 1'b1);
        check("m_data_done", m_data, v.exp_m);
        check("busy_done", busy, 1'b0);
        check("tick_done", shift_tick, 1'b0);
        sin = 1'b0;
        step();
        check("m_valid_pulse_end", m_valid, 1'b0);
        check("ready_idle", s_ready, 1'b1);
        check("m_data_held", m_data, v.exp_m);
    endtask

    initial begin
        int n_mv;
        int loads;
        int pulses;
        int ticks;
        int waited;
        logic [1:0] b_exp_sout [4];

        vecs[0] = '{8'hA5, 1'b0, 8'h81, 8'hA5, 8'h81};
        vecs[1] = '{8'hC3, 1'b1, 8'h01, 8'hC3, 8'h80};
        vecs[2] = '{8'h3C, 1'b0, 8'h5A, 8'h3C, 8'h5A};
        vecs[3] = '{8'h96, 1'b1, 8'hF0, 8'h69, 8'h0F};
        b_exp_sout = '{2'b11, 2'b10, 2'b01, 2'b00};

        clrn      = 1'b0;
        sclr      = 1'b1;
        dir       = 1'b0;
        s_valid   = 1'b0;
        s_data    = 8'h00;
        sin       = 1'b0;
        b_s_valid = 1'b0;
        b_s_data  = 8'h00;
        b_sin     = 2'b00;

        step();
        step();
        check("rst_s_ready", s_ready, 1'b1);
        check("rst_sout", sout, 1'b0);
        check("rst_shift_tick", shift_tick, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, 8'h00);
        check("rst_b_s_ready", b_s_ready, 1'b1);
        check("rst_b_m_data", b_m_data, 8'h00);
        clrn = 1'b1;
        step();

        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i], (i == 1) ? 3 : -1);
        end

        // Synchronous clear during step 4 drops the frame without m_valid.
        s_data  = 8'hA5;
        dir     = 1'b1;
        sin     = 1'b1;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        step();
        step();
        step();
        sclr = 1'b0;
        step();
        sclr = 1'b1;
        check("sclr_s_ready", s_ready, 1'b1);
        check("sclr_busy", busy, 1'b0);
        check("sclr_m_data", m_data, 8'h00);
        check("sclr_sout", sout, 1'b0);
        check("sclr_tick", shift_tick, 1'b0);
        n_mv = 0;
        for (int c = 0; c < 12; c++) begin
            if (m_valid) n_mv++;
            step();
        end
        check("sclr_no_m_valid", n_mv, 0);
        sin = 1'b0;
        run_frame(vecs[2], -1);

        // s_valid held high: one load per PERIOD cycles, one m_valid per frame.
        s_data  = 8'h5A;
        dir     = 1'b0;
        sin     = 1'b0;
        s_valid = 1'b1;
        loads   = 0;
        pulses  = 0;
        for (int c = 0; c < 3 * PERIOD; c++) begin
            if (s_ready) begin
                check("hold_load_cycle", c, loads * PERIOD);
                loads++;
            end
            step();
            if (m_valid) pulses++;
        end
        s_valid = 1'b0;
        check("hold_loads", loads, 3);
        check("hold_pulses", pulses, 3);
        waited = 0;
        while (!(s_ready && !busy) && waited < 30) begin
            step();
            waited++;
        end
        check("hold_idle_timeout", (waited < 30), 1'b1);

        // Two lanes, divider 3.
        b_s_data  = 8'h1B;
        b_sin     = 2'b11;
        b_s_valid = 1'b1;
        step();
        b_s_valid = 1'b0;
        ticks = 0;
        for (int c = 0; c < 12; c++) begin
            check("b_tick", b_shift_tick, (c % 3 == 2));
            check("b_sout", b_sout, b_exp_sout[c / 3]);
            check("b_m_valid_early", b_m_valid, 1'b0);
            if (b_shift_tick) ticks++;
            step();
        end
        check("b_ticks", ticks, 4);
        check("b_m_valid", b_m_valid, 1'b1);
        check("b_m_data", b_m_data, 8'hFF);
        step();
        check("b_m_valid_end", b_m_valid, 1'b0);
        check("b_ready_idle", b_s_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_frame_engine.md
# shift_frame_engine

Parametrised full-duplex frame shifter for the serial-link primitives library. It accepts a WIDTH-bit parallel word over a valid/ready handshake and shifts it out LANES bits at a time at a programmable rate. At the same time it shifts in LANES bits per step and, at the end of the frame, returns the captured word as a one-cycle parallel result. Shift direction is selected per frame. It serves as the common core for SPI-like and strobe-based serializers.

## Interface
- WIDTH, 8, frame width in bits; WIDTH % LANES == 0, WIDTH >= LANES
- LANES, 1, bits shifted per step (1 = serial, >1 = multi-lane)
- DIV, 1, clock cycles per shift step, >= 1
- clk  in  1  clock
- clrn  in  1  reset, asynchronous, active-low
- sclr  in  1  synchronous clear, active-low, aborts any frame
- dir  in  1  0 = right (LSB first), 1 = left (MSB first); sampled only at load
- s_valid  in  1  load request
- s_ready  out  1  engine can accept a load
- s_data  in  WIDTH  word to transmit
- sin  in  LANES  incoming bits
- sout  out  LANES  outgoing bits
- shift_tick  out  1  high in the cycle whose ending edge performs a shift
- busy  out  1  frame in progress
- m_valid  out  1  one-cycle pulse, frame complete
- m_data  out  WIDTH  captured word, valid while m_valid=1

## Operation
- States: IDLE, SHIFT, DONE. After reset and after sclr=0: IDLE, shift register 0, step/divider counters 0, dir latch 0.
- IDLE: s_ready=1. A load happens when s_valid&s_ready at an edge: the register takes s_data, dir is latched, the step counter is set to N=WIDTH/LANES, the divider is set to DIV-1, and the state goes to SHIFT.
- SHIFT: s_ready=0, busy=1. The divider counts down. shift_tick=1 when the divider is 0; at that edge the divider reloads to DIV-1, the register shifts, and the step counter decrements. When the counter reaches 0 the state goes to DONE.
- Right shift: q <= {sin, q[WIDTH-1:LANES]}; sout = q[LANES-1:0].
- Left shift: q <= {q[WIDTH-LANES-1:0], sin}; sout = q[WIDTH-1:WIDTH-LANES]. When WIDTH==LANES, q <= sin.
- sout is driven from the register continuously and is meaningful from the load edge onward.
- DONE lasts one cycle: m_valid=1, busy=0, m_data=q. Then IDLE.
- The register holds its value in DONE and IDLE until the next load; m_data always equals q.
- s_valid while s_ready=0 is ignored; no queueing.
- sclr=0 has priority over everything except clrn. The frame is dropped and no m_valid is produced.
- clrn is asserted asynchronously and released synchronously by the user's reset bridge.

## Timing
- Reset values: s_ready=1, sout=0, shift_tick=0, busy=0, m_valid=0, m_data=0.
- Load edge E0. Shift k (k=1..N) occurs at edge E0+k*DIV. DONE occupies the cycle after E0+N*DIV. m_valid is high between edges E0+N*DIV and E0+N*DIV+1.
- sin is sampled only at shift edges.
- Minimum frame period, load to next load: N*DIV+2 cycles (N*DIV+1 with the back-to-back feature).

## Configuration
- SHIFT_FRAME_ENGINE_B2B_EN defined: s_ready=1 in DONE as well. A load accepted in DONE goes directly to SHIFT. m_valid and m_data for the finished frame are still presented in that cycle, because q updates only at the edge.
- SHIFT_FRAME_ENGINE_B2B_EN undefined: s_ready=0 in DONE, and at least one IDLE cycle separates frames.

## Test plan
- WIDTH=8, LANES=1, DIV=1, dir=0: load 0xA5, drive sin 1,0,0,0,0,0,0,1 → sout 1,0,1,0,0,1,0,1 on successive steps; m_valid one cycle, 9 cycles after the load edge; m_data=0x81.
- dir=1: load 0xC3, drive sin 1 then 0s → sout 1,1,0,0,0,0,1,1; m_data=0x80.
- LANES=2, DIV=3: load 0x1B, sin=2'b11 constant → sout 2'b11,2'b10,2'b01,2'b00; shift_tick every 3rd cycle; 4 ticks; m_data=0xFF; m_valid 13 cycles after load.
- sclr=0 during step 4 → next cycle IDLE, q=0, s_ready=1, no m_valid. A new load afterwards completes normally.
- s_valid held high continuously, WIDTH=8, DIV=1 → loads every 10 cycles without the macro and every 9 cycles with it; exactly one m_valid per frame.
- s_valid pulsed with a different word mid-frame → ignored; m_data of the current frame is unaffected.
